// File: rtl/mac_pkg.sv
// Shared encodings for the dual-dataflow MAC tile: instruction bit positions,
// dataflow mode values and the weight-load state.
package mac_pkg;
  localparam int INST_LOAD  = 0;
  localparam int INST_EXEC  = 1;
  localparam int INST_FLUSH = 2;
  localparam int INST_W     = 3;

  localparam logic MODE_WS = 1'b0;
  localparam logic MODE_OS = 1'b1;

  typedef enum logic {LOADING, READY} load_state_e;
endpackage

// File: rtl/mac_dm_unit.sv
// Combinational y = zext(a) * signed(w) + c. Wraps by default;
// with MAC_SAT_EN defined the sum clamps to the signed psum_bw range.
module mac_dm_unit
  import mac_pkg::*;
#(
  parameter int bw      = 4,
  parameter int psum_bw = 16
) (
  input  logic        [bw-1:0]      a,
  input  logic signed [bw-1:0]      w,
  input  logic signed [psum_bw-1:0] c,
  output logic signed [psum_bw-1:0] y
);
  localparam int PW = 2*bw + 1;
  localparam int SW = ((PW > psum_bw) ? PW : psum_bw) + 1;

  logic signed [PW-1:0] prod;
  logic signed [SW-1:0] sum;

  // One guard bit above both operands so the saturating compare sees true overflow.
  assign prod = PW'($signed({1'b0, a})) * PW'(w);
  assign sum  = SW'(prod) + SW'(c);

`ifdef MAC_SAT_EN
  localparam logic signed [SW-1:0] SMAX = SW'($signed({1'b0, {(psum_bw-1){1'b1}}}));
  localparam logic signed [SW-1:0] SMIN = SW'($signed({1'b1, {(psum_bw-1){1'b0}}}));

  always_comb begin
    if (sum > SMAX)      y = SMAX[psum_bw-1:0];
    else if (sum < SMIN) y = SMIN[psum_bw-1:0];
    else                 y = sum[psum_bw-1:0];
  end
`else
  logic unused_hi;
  assign unused_hi = ^sum[SW-1:psum_bw];
  assign y         = sum[psum_bw-1:0];
`endif
endmodule

// File: rtl/mac_tile_dm.sv
// Systolic PE with NK stationary weight slots and WS / OS dataflow modes.
// Optional saturating accumulation via MAC_SAT_EN (see mac_dm_unit).
module mac_tile_dm
  import mac_pkg::*;
#(
  parameter int bw      = 4,
  parameter int psum_bw = 16,
  parameter int sel_bw  = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                mode,
  input  logic [bw-1:0]       in_w,
  output logic [bw-1:0]       out_e,
  input  logic [INST_W-1:0]   inst_w,
  output logic [INST_W-1:0]   inst_e,
  input  logic [sel_bw-1:0]   sel_w,
  output logic [sel_bw-1:0]   sel_e,
  input  logic [psum_bw-1:0]  in_n,
  output logic [psum_bw-1:0]  out_s,
  output logic                loaded
);
  localparam int NK = 2**sel_bw;

  logic [bw-1:0]             a_q, wb_q;
  logic [NK-1:0][bw-1:0]     w_q;
  logic [psum_bw-1:0]        c_q, acc_q, os_out_q;
  logic [INST_W-1:0]         inst_q;
  logic [sel_bw-1:0]         sel_q, wr_ptr;
  logic [psum_bw-1:0]        ws_y, os_y;
  load_state_e               state_q, state_d;
  logic                      load_wr;

  always_ff @(posedge clk) begin
    if (reset) state_q <= LOADING;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    load_wr = 1'b0;
    if (state_q == LOADING && inst_w[INST_LOAD]) begin
      load_wr = 1'b1;
      if (wr_ptr == sel_bw'(NK-1)) state_d = READY;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q      <= '0;
      w_q      <= '0;
      c_q      <= '0;
      acc_q    <= '0;
      wb_q     <= '0;
      os_out_q <= '0;
      inst_q   <= '0;
      sel_q    <= '0;
      wr_ptr   <= '0;
    end else begin
      if (inst_w != '0) a_q <= in_w;
      if (load_wr) begin
        w_q[wr_ptr] <= in_w;
        wr_ptr      <= wr_ptr + sel_bw'(1);
      end
      // Loads are consumed locally until this tile is full, then pass east.
      inst_q[INST_LOAD]  <= inst_w[INST_LOAD] && (state_q == READY);
      inst_q[INST_EXEC]  <= inst_w[INST_EXEC];
      inst_q[INST_FLUSH] <= inst_w[INST_FLUSH];
      sel_q              <= sel_w;
      c_q                <= in_n;
      if (mode == MODE_OS) begin
        if (inst_w[INST_FLUSH]) begin
          os_out_q <= acc_q;
          acc_q    <= in_n;
        end else if (inst_w[INST_EXEC]) begin
          wb_q  <= in_n[bw-1:0];
          acc_q <= os_y;
        end
      end
    end
  end

  mac_dm_unit #(.bw(bw), .psum_bw(psum_bw)) u_ws (
    .a(a_q), .w(w_q[sel_q]), .c(c_q), .y(ws_y)
  );

  mac_dm_unit #(.bw(bw), .psum_bw(psum_bw)) u_os (
    .a(in_w), .w(in_n[bw-1:0]), .c(acc_q), .y(os_y)
  );

  // inst_q[FLUSH] marks the cycle after a flush, when the drain value is on out_s.
  assign out_s  = (mode == MODE_WS)   ? ws_y :
                  inst_q[INST_FLUSH]  ? os_out_q :
                                        {{(psum_bw-bw){wb_q[bw-1]}}, wb_q};
  assign out_e  = a_q;
  assign inst_e = inst_q;
  assign sel_e  = sel_q;
  assign loaded = (state_q == READY);
endmodule

// File: tb/tb_mac_tile_dm.sv
// Scoreboard bench for mac_tile_dm: directed scenarios plus random traffic
// compared against an integer-arithmetic reference model.
module tb_mac_tile_dm;
  localparam int BW = 4, PSUM_BW = 8, SEL_BW = 1, NK = 2;
  localparam int PMAX = (1 << (PSUM_BW-1)) - 1;
  localparam int PMIN = -(1 << (PSUM_BW-1));

  logic clk = 1'b0;
  logic reset, mode;
  logic [BW-1:0] in_w, out_e;
  logic [2:0] inst_w, inst_e;
  logic [SEL_BW-1:0] sel_w, sel_e;
  logic [PSUM_BW-1:0] in_n, out_s;
  logic loaded;

  always #5 clk = ~clk;

  mac_tile_dm #(.bw(BW), .psum_bw(PSUM_BW), .sel_bw(SEL_BW)) dut (
    .clk(clk), .reset(reset), .mode(mode), .in_w(in_w), .out_e(out_e),
    .inst_w(inst_w), .inst_e(inst_e), .sel_w(sel_w), .sel_e(sel_e),
    .in_n(in_n), .out_s(out_s), .loaded(loaded)
  );

  typedef struct {
    int step; int out_s; int out_e; int inst_e; int sel_e; int loaded;
  } exp_t;
  exp_t sb[$];
  int checks = 0, failures = 0, nstep = 0;

  // reference model state, in plain integers
  int m_w[NK];
  int m_nl, m_a, m_c, m_acc, m_wb, m_os, m_flushed, m_inst_e, m_sel_e;

  function automatic int sx(int v, int width);
    return (v >= (1 << (width-1))) ? v - (1 << width) : v;
  endfunction

  function automatic int fit(int v);
`ifdef MAC_SAT_EN
    if (v > PMAX) return PMAX;
    if (v < PMIN) return PMIN;
    return v;
`else
    int m;
    m = 1 << PSUM_BW;
    return ((v - PMIN) % m + m) % m + PMIN;
`endif
  endfunction

  task automatic step(input int r, input int md, input int iw, input int inst,
                      input int sel, input int n);
    exp_t e;
    int av, wv, nv;
    @(negedge clk);
    reset = r[0]; mode = md[0]; in_w = iw[BW-1:0]; inst_w = inst[2:0];
    sel_w = sel[SEL_BW-1:0]; in_n = n[PSUM_BW-1:0];
    av = iw & 15; wv = sx(n & 15, 4); nv = sx(n & 255, 8);
    if (r != 0) begin
      foreach (m_w[k]) m_w[k] = 0;
      m_nl = 0; m_a = 0; m_c = 0; m_acc = 0; m_wb = 0; m_os = 0;
      m_flushed = 0; m_inst_e = 0; m_sel_e = 0;
    end else begin
      m_inst_e = inst & 6;
      if (m_nl == NK) m_inst_e = m_inst_e | (inst & 1);
      if ((inst & 1) != 0 && m_nl < NK) begin
        m_w[m_nl] = sx(av, 4);
        m_nl++;
      end
      if (inst != 0) m_a = av;
      m_sel_e = sel;
      m_c = nv;
      if (md != 0) begin
        if ((inst & 4) != 0) begin
          m_os = m_acc; m_acc = nv;
        end else if ((inst & 2) != 0) begin
          m_wb = wv; m_acc = fit(m_acc + av * wv);
        end
      end
      m_flushed = (inst >> 2) & 1;
    end
    e.step   = nstep++;
    e.out_s  = (md == 0) ? fit(m_a * m_w[m_sel_e] + m_c) : (m_flushed != 0 ? m_os : m_wb);
    e.out_e  = m_a;
    e.inst_e = m_inst_e;
    e.sel_e  = m_sel_e;
    e.loaded = (m_nl == NK) ? 1 : 0;
    sb.push_back(e);
  endtask

  task automatic check(input string name, input int stp, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s step=%0d got=%0d expected=%0d", name, stp, got, want);
    end
  endtask

  // monitor: one expected entry per cycle, compared just after the active edge
  initial begin
    exp_t e;
    int got_s;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        got_s = $signed(out_s);
        check("out_s",  e.step, got_s,        e.out_s);
        check("out_e",  e.step, int'(out_e),  e.out_e);
        check("inst_e", e.step, int'(inst_e), e.inst_e);
        check("sel_e",  e.step, int'(sel_e),  e.sel_e);
        check("loaded", e.step, int'(loaded), e.loaded);
      end
    end
  end

  logic prev_mode = 1'b0;
  always @(posedge clk) begin
    if (!reset)
      assert (!(mode !== prev_mode && inst_w != 3'b000))
        else $error("mode switched while an instruction was active");
    prev_mode <= mode;
  end

  initial begin
    int md, t;
    reset = 1'b1; mode = 1'b0; in_w = '0; inst_w = '0; sel_w = '0; in_n = '0;
    step(1,0,0,0,0,0); step(1,0,0,0,0,0);
    // fill both slots (3, -2), then a load that must pass east
    step(0,0,3,1,0,0); step(0,0,14,1,0,0); step(0,0,5,1,0,0);
    // WS execute: 5*-2+100, 5*3+100
    step(0,0,5,2,1,100); step(0,0,5,2,0,100); step(0,0,0,0,0,0);
    // WS overflow: 15*7+120 in 8 bits
    step(1,0,0,0,0,0); step(0,0,7,1,0,0); step(0,0,7,1,0,0);
    step(0,0,15,2,0,120); step(0,0,0,0,0,0);
    // OS accumulate (2,3) (7,-1) (15,7) then two flushes
    step(0,1,0,0,0,0);
    step(0,1,2,2,0,3); step(0,1,7,2,0,15); step(0,1,15,2,0,7);
    step(0,1,0,4,0,55); step(0,1,0,4,0,0); step(0,1,0,0,0,0);
    // execute + flush together: flush wins
    step(0,1,9,6,0,5); step(0,1,0,4,0,0);
    // reset in the middle of loading
    step(0,0,0,0,0,0); step(1,0,0,0,0,0); step(0,0,9,1,0,0);
    step(1,0,0,0,0,0); step(0,0,0,0,0,0);
    step(0,0,4,1,0,0); step(0,0,1,1,1,0); step(0,0,2,2,0,0); step(0,0,3,2,1,0);
    // random traffic, mode toggled only on idle cycles
    md = 0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0,19) == 0) begin
        md = 1 - md;
        step(0, md, $urandom_range(0,15), 0, $urandom_range(0,1), $urandom_range(0,255));
      end else if ($urandom_range(0,49) == 0) begin
        step(1, md, 0, 0, 0, 0);
      end else begin
        step(0, md, $urandom_range(0,15), $urandom_range(0,7),
             $urandom_range(0,1), $urandom_range(0,255));
      end
    end
    t = 0;
    while (sb.size() > 0 && t < 10) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() > 0) begin
      checks++; failures++;
      $display("FAIL drain pending=%0d expected=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
